// File: rtl/mage_pkg.sv
// Shared Mage types and data-memory front-end constants.
package mage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [31:0] DMEM_BASE_ADDR   = 32'hF000_0000;
    localparam int unsigned DMEM_REGION_W    = 20;
    localparam int unsigned DMEM_STALL_MAX   = 4;
    localparam int unsigned DMEM_N_BANKS     = 8;
    localparam int unsigned DMEM_BANK_ADDR_W = 10;
    localparam int unsigned DMEM_DATA_W      = 32;
    localparam int unsigned DMEM_BANK_IDX_W  = 8;

    // Registered context of one granted external access.
    typedef struct packed {
        logic [DMEM_BANK_IDX_W-1:0] bank;
        logic                       we;
        logic                       err;
    } dmem_ext_rsp_t;

endpackage

// File: rtl/dmem_addr_map.sv
// Maps an external byte address onto (bank, bank word address) with a
// runtime power-of-two interleave, and flags addresses outside the region.
module dmem_addr_map
    import mage_pkg::*;
#(
    parameter int unsigned N_BANKS     = DMEM_N_BANKS,
    parameter int unsigned BANK_ADDR_W = DMEM_BANK_ADDR_W,
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned REGION_W    = DMEM_REGION_W
) (
    input  logic [31:0]                  addr_i,
    input  logic [3:0]                   block_size_i,
    output logic [$clog2(N_BANKS)-1:0]   bank_o,
    output logic [BANK_ADDR_W-1:0]       bank_addr_o,
    output logic                         in_range_o
);

    localparam int unsigned BANK_W      = $clog2(N_BANKS);
    localparam int unsigned OFF_W       = $clog2(DATA_W / 8);
    localparam logic [31:0] REGION_MASK = 32'((64'd1 << REGION_W) - 64'd1);

    logic [31:0] word;
    logic [31:0] low_mask;
    logic [31:0] region_off;
    int unsigned ke;

    always_comb begin
        word       = addr_i >> OFF_W;
        ke         = (32'(block_size_i) < BANK_ADDR_W) ? 32'(block_size_i) : BANK_ADDR_W;
        low_mask   = (32'd1 << ke) - 32'd1;
        region_off = addr_i & REGION_MASK;

        bank_o      = BANK_W'(word >> ke);
        // High word bits skip over the bank-select field, low bits stay in place.
        bank_addr_o = BANK_ADDR_W'(((word >> (ke + BANK_W)) << ke) | (word & low_mask));
        in_range_o  = ((addr_i >> REGION_W) == (BASE_ADDR >> REGION_W)) &&
                      ((region_off >> (OFF_W + BANK_ADDR_W + BANK_W)) == 32'd0);
    end

endmodule

// File: rtl/dmem_bank_arbiter.sv
// Per-bank arbiter between the Mage PEA ports and one external bus port,
// with starvation protection for the external master and a 1-stage response.
module dmem_bank_arbiter
    import mage_pkg::*;
#(
    parameter int unsigned N_BANKS     = DMEM_N_BANKS,
    parameter int unsigned BANK_ADDR_W = DMEM_BANK_ADDR_W,
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned REGION_W    = DMEM_REGION_W,
    parameter int unsigned STALL_MAX   = DMEM_STALL_MAX
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  state_t                                  state_i,
    input  logic [3:0]                              reg_block_size_i,

    input  logic [N_BANKS-1:0]                      mage_req_i,
    input  logic [N_BANKS-1:0]                      mage_we_i,
    input  logic [N_BANKS-1:0][BANK_ADDR_W-1:0]     mage_addr_i,
    input  logic [N_BANKS-1:0][DATA_W-1:0]          mage_wdata_i,
    output logic [N_BANKS-1:0]                      mage_stall_o,
    output logic [N_BANKS-1:0]                      mage_rvalid_o,
    output logic [N_BANKS-1:0][DATA_W-1:0]          mage_rdata_o,

    input  logic                                    ext_req_i,
    input  logic                                    ext_we_i,
    input  logic [DATA_W/8-1:0]                     ext_be_i,
    input  logic [31:0]                             ext_addr_i,
    input  logic [DATA_W-1:0]                       ext_wdata_i,
    output logic                                    ext_gnt_o,
    output logic                                    ext_rvalid_o,
    output logic [DATA_W-1:0]                       ext_rdata_o,
    output logic                                    ext_err_o,

    output logic [N_BANKS-1:0]                      dmem_req_o,
    output logic [N_BANKS-1:0]                      dmem_we_o,
    output logic [N_BANKS-1:0][DATA_W/8-1:0]        dmem_be_o,
    output logic [N_BANKS-1:0][BANK_ADDR_W-1:0]     dmem_addr_o,
    output logic [N_BANKS-1:0][DATA_W-1:0]          dmem_wdata_o,
    input  logic [N_BANKS-1:0][DATA_W-1:0]          dmem_rdata_i
);

    localparam int unsigned BANK_W = $clog2(N_BANKS);
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(STALL_MAX + 1);

    logic [BANK_W-1:0]      ext_bank;
    logic [BANK_ADDR_W-1:0] ext_baddr;
    logic                   ext_in_range;

    logic [CNT_W-1:0]       deny_cnt_q, deny_cnt_d;
    dmem_ext_rsp_t          rsp_q, rsp_d;
    logic                   rsp_vld_q, rsp_vld_d;
    logic [N_BANKS-1:0]     mage_rd_q, mage_rd_d;

    logic                   exec;
    logic [N_BANKS-1:0]     mage_act;
    logic                   conflict;
    logic                   force_ext;
    logic                   ext_gnt;
    logic                   ext_bank_gnt;
    logic                   ext_own;
    logic [BANK_W-1:0]      rsp_bank;

    dmem_addr_map #(
        .N_BANKS     (N_BANKS),
        .BANK_ADDR_W (BANK_ADDR_W),
        .DATA_W      (DATA_W),
        .BASE_ADDR   (BASE_ADDR),
        .REGION_W    (REGION_W)
    ) u_addr_map (
        .addr_i       (ext_addr_i),
        .block_size_i (reg_block_size_i),
        .bank_o       (ext_bank),
        .bank_addr_o  (ext_baddr),
        .in_range_o   (ext_in_range)
    );

    // Arbitration, bank muxing and next response state.
    always_comb begin
        exec         = (state_i == EXEC);
        mage_act     = exec ? mage_req_i : '0;
        conflict     = ext_req_i && ext_in_range && mage_act[ext_bank];
        force_ext    = conflict && (deny_cnt_q == CNT_W'(STALL_MAX));
        ext_gnt      = ext_req_i && (!ext_in_range || !conflict || force_ext);
        ext_bank_gnt = ext_gnt && ext_in_range;
        ext_gnt_o    = ext_gnt;
        deny_cnt_d   = (!ext_req_i || ext_gnt) ? '0 : deny_cnt_q + CNT_W'(1);

        mage_stall_o = '0;
        mage_rd_d    = '0;
        dmem_req_o   = '0;
        dmem_we_o    = '0;
        dmem_be_o    = '0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        ext_own      = 1'b0;

        for (int unsigned i = 0; i < N_BANKS; i++) begin
            ext_own = ext_bank_gnt && (ext_bank == BANK_W'(i));
            // Outside EXEC every Mage request is reported as not serviced.
            mage_stall_o[i] = exec ? (mage_req_i[i] && ext_own) : mage_req_i[i];
            if (ext_own) begin
                dmem_req_o[i]   = 1'b1;
                dmem_we_o[i]    = ext_we_i;
                dmem_be_o[i]    = ext_be_i;
                dmem_addr_o[i]  = ext_baddr;
                dmem_wdata_o[i] = ext_wdata_i;
            end else if (mage_act[i]) begin
                dmem_req_o[i]   = 1'b1;
                dmem_we_o[i]    = mage_we_i[i];
                dmem_be_o[i]    = {BE_W{1'b1}};
                dmem_addr_o[i]  = mage_addr_i[i];
                dmem_wdata_o[i] = mage_wdata_i[i];
                mage_rd_d[i]    = !mage_we_i[i];
            end
        end

        rsp_vld_d  = ext_gnt;
        rsp_d.bank = DMEM_BANK_IDX_W'(ext_bank);
        rsp_d.we   = ext_we_i;
        rsp_d.err  = !ext_in_range;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deny_cnt_q <= '0;
            rsp_q      <= '0;
            rsp_vld_q  <= 1'b0;
            mage_rd_q  <= '0;
        end else begin
            deny_cnt_q <= deny_cnt_d;
            rsp_q      <= rsp_d;
            rsp_vld_q  <= rsp_vld_d;
            mage_rd_q  <= mage_rd_d;
        end
    end

    // Response outputs: registered context qualifies the banks' read data.
    always_comb begin
        rsp_bank     = BANK_W'(rsp_q.bank);
        ext_rvalid_o = rsp_vld_q;
        ext_err_o    = rsp_vld_q && rsp_q.err;
        ext_rdata_o  = (rsp_vld_q && !rsp_q.we && !rsp_q.err) ? dmem_rdata_i[rsp_bank] : '0;
        mage_rvalid_o = mage_rd_q;
        for (int unsigned i = 0; i < N_BANKS; i++) begin
            mage_rdata_o[i] = mage_rd_q[i] ? dmem_rdata_i[i] : '0;
        end
    end

endmodule

// File: tb/tb_dmem_bank_arbiter.sv
// Directed bench for dmem_bank_arbiter with a byte-enable bank memory model.
module tb_dmem_bank_arbiter;
    import mage_pkg::*;

    localparam int unsigned NB = 8;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    state_t                    st;
    logic [3:0]                k;
    logic [NB-1:0]             mage_req, mage_we, mage_stall, mage_rvalid;
    logic [NB-1:0][AW-1:0]     mage_addr;
    logic [NB-1:0][DW-1:0]     mage_wdata, mage_rdata;
    logic                      ext_req, ext_we, ext_gnt, ext_rvalid, ext_err;
    logic [3:0]                ext_be;
    logic [31:0]               ext_addr;
    logic [DW-1:0]             ext_wdata, ext_rdata;
    logic [NB-1:0]             dmem_req, dmem_we;
    logic [NB-1:0][3:0]        dmem_be;
    logic [NB-1:0][AW-1:0]     dmem_addr;
    logic [NB-1:0][DW-1:0]     dmem_wdata, dmem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_bank_arbiter dut (
        .clk_i(clk), .rst_i(rst), .state_i(st), .reg_block_size_i(k),
        .mage_req_i(mage_req), .mage_we_i(mage_we), .mage_addr_i(mage_addr),
        .mage_wdata_i(mage_wdata), .mage_stall_o(mage_stall),
        .mage_rvalid_o(mage_rvalid), .mage_rdata_o(mage_rdata),
        .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_be_i(ext_be),
        .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata), .ext_gnt_o(ext_gnt),
        .ext_rvalid_o(ext_rvalid), .ext_rdata_o(ext_rdata), .ext_err_o(ext_err),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_be_o(dmem_be),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata)
    );

    // Banked memory with one-cycle read latency and byte-enable writes.
    logic [31:0] mem [NB][1024];
    logic [31:0] tmp;
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (dmem_req[b]) begin
                dmem_rdata[b] <= mem[b][dmem_addr[b]];
                if (dmem_we[b]) begin
                    tmp = mem[b][dmem_addr[b]];
                    for (int j = 0; j < 4; j++)
                        if (dmem_be[b][j]) tmp[8*j +: 8] = dmem_wdata[b][8*j +: 8];
                    mem[b][dmem_addr[b]] <= tmp;
                end
            end
        end
    end

    task automatic drive(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        ext_req = req; ext_we = we; ext_be = be; ext_addr = addr; ext_wdata = wdata;
    endtask

    task automatic test_reset;
        rst = 1'b1; st = IDLE; k = 4'd0;
        mage_req = '0; mage_we = '0; mage_addr = '0; mage_wdata = '0;
        dmem_rdata = '0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        checks += 6;
        if (ext_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", ext_rvalid); end
        if (ext_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", ext_err); end
        if (mage_rvalid !== 8'h00) begin failures++; $display("FAIL reset_mage_rvalid got=%h exp=00", mage_rvalid); end
        if (ext_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", ext_rdata); end
        if (dmem_req !== 8'h00) begin failures++; $display("FAIL reset_dmem_req got=%h exp=00", dmem_req); end
        if (ext_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", ext_gnt); end
        rst = 1'b0;
    endtask

    task automatic test_write_k0;
        k = 4'd0;
        @(negedge clk);
        drive(1'b1, 1'b1, 4'hF, 32'hF000_0014, 32'hA5A5_A5A5);
        #1;
        checks += 4;
        if (ext_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", ext_gnt); end
        if (dmem_req !== 8'h20) begin failures++; $display("FAIL wr_bank got=%h exp=20", dmem_req); end
        if (dmem_addr[5] !== 10'd0) begin failures++; $display("FAIL wr_addr got=%0d exp=0", dmem_addr[5]); end
        if (dmem_we[5] !== 1'b1) begin failures++; $display("FAIL wr_we got=%b exp=1", dmem_we[5]); end
        @(negedge clk);
        checks += 2;
        if (ext_rvalid !== 1'b1) begin failures++; $display("FAIL wr_rvalid got=%b exp=1", ext_rvalid); end
        if (ext_err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", ext_err); end
        drive(1'b1, 1'b0, 4'hF, 32'hF000_0014, 32'h0);
        @(negedge clk);
        checks += 1;
        if (ext_rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wr_readback got=%h exp=a5a5a5a5", ext_rdata); end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checks += 1;
        if (ext_rvalid !== 1'b0) begin failures++; $display("FAIL idle_rvalid got=%b exp=0", ext_rvalid); end
    endtask

    task automatic test_read_k10;
        k = 4'd10;
        @(negedge clk);
        drive(1'b1, 1'b1, 4'hF, 32'hF000_1008, 32'h1234_5678);
        #1;
        checks += 2;
        if (dmem_req !== 8'h02) begin failures++; $display("FAIL k10_bank got=%h exp=02", dmem_req); end
        if (dmem_addr[1] !== 10'd2) begin failures++; $display("FAIL k10_addr got=%0d exp=2", dmem_addr[1]); end
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'hF000_1008, 32'h0);
        #1;
        checks += 1;
        if (ext_gnt !== 1'b1) begin failures++; $display("FAIL k10_rd_gnt got=%b exp=1", ext_gnt); end
        @(negedge clk);
        k = 4'd0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checks += 1;
        if (ext_rdata !== 32'h1234_5678) begin failures++; $display("FAIL k10_rdata got=%h exp=12345678", ext_rdata); end
    endtask

    task automatic test_conflict;
        k = 4'd0; st = EXEC;
        mage_req = 8'h08; mage_we = '0; mage_addr[3] = 10'd7;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) drive(1'b1, 1'b0, 4'hF, 32'hF000_000C, 32'h0);
            else begin
                checks += 1;
                if (mage_rvalid[3] !== 1'b1) begin failures++; $display("FAIL cf_mage_rvalid c=%0d got=%b exp=1", c, mage_rvalid[3]); end
            end
            #1;
            checks += 3;
            if (ext_gnt !== (c == 5)) begin failures++; $display("FAIL cf_gnt c=%0d got=%b exp=%b", c, ext_gnt, c == 5); end
            if (mage_stall[3] !== (c == 5)) begin failures++; $display("FAIL cf_stall c=%0d got=%b exp=%b", c, mage_stall[3], c == 5); end
            if (dmem_addr[3] !== ((c == 5) ? 10'd0 : 10'd7)) begin failures++; $display("FAIL cf_addr c=%0d got=%0d", c, dmem_addr[3]); end
        end
        @(negedge clk);
        checks += 2;
        if (mage_rvalid[3] !== 1'b0) begin failures++; $display("FAIL cf_stalled_rvalid got=%b exp=0", mage_rvalid[3]); end
        if (ext_rvalid !== 1'b1) begin failures++; $display("FAIL cf_ext_rvalid got=%b exp=1", ext_rvalid); end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checks += 2;
        if (mage_stall[3] !== 1'b0) begin failures++; $display("FAIL cf_stall_clear got=%b exp=0", mage_stall[3]); end
        if (dmem_req !== 8'h08) begin failures++; $display("FAIL cf_mage_req got=%h exp=08", dmem_req); end
        st = IDLE; mage_req = 8'h04;
        #1;
        checks += 2;
        if (mage_stall !== 8'h04) begin failures++; $display("FAIL noexec_stall got=%h exp=04", mage_stall); end
        if (dmem_req !== 8'h00) begin failures++; $display("FAIL noexec_req got=%h exp=00", dmem_req); end
        mage_req = '0;
    endtask

    task automatic test_oor;
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'hE000_0000, 32'h0);
        #1;
        checks += 2;
        if (ext_gnt !== 1'b1) begin failures++; $display("FAIL oor_gnt got=%b exp=1", ext_gnt); end
        if (dmem_req !== 8'h00) begin failures++; $display("FAIL oor_req got=%h exp=00", dmem_req); end
        @(negedge clk);
        checks += 3;
        if (ext_rvalid !== 1'b1) begin failures++; $display("FAIL oor_rvalid got=%b exp=1", ext_rvalid); end
        if (ext_err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", ext_err); end
        if (ext_rdata !== 32'h0) begin failures++; $display("FAIL oor_rdata got=%h exp=0", ext_rdata); end
        drive(1'b1, 1'b0, 4'hF, 32'hF000_8000, 32'h0);
        #1;
        checks += 1;
        if (dmem_req !== 8'h00) begin failures++; $display("FAIL oor_edge_req got=%h exp=00", dmem_req); end
        @(negedge clk);
        checks += 1;
        if (ext_err !== 1'b1) begin failures++; $display("FAIL oor_edge_err got=%b exp=1", ext_err); end
        drive(1'b1, 1'b0, 4'hF, 32'hF000_7FFC, 32'h0);
        #1;
        checks += 2;
        if (dmem_req !== 8'h80) begin failures++; $display("FAIL top_req got=%h exp=80", dmem_req); end
        if (dmem_addr[7] !== 10'h3FF) begin failures++; $display("FAIL top_addr got=%h exp=3ff", dmem_addr[7]); end
        @(negedge clk);
        checks += 1;
        if (ext_err !== 1'b0) begin failures++; $display("FAIL top_err got=%b exp=0", ext_err); end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_partial;
        @(negedge clk);
        drive(1'b1, 1'b1, 4'hF, 32'hF000_0010, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'b0010, 32'hF000_0010, 32'h0000_3C00);
        #1;
        checks += 2;
        if (dmem_be[4] !== 4'b0010) begin failures++; $display("FAIL pw_be got=%b exp=0010", dmem_be[4]); end
        if (dmem_req !== 8'h10) begin failures++; $display("FAIL pw_req got=%h exp=10", dmem_req); end
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'hF000_0010, 32'h0);
        @(negedge clk);
        checks += 1;
        if (ext_rdata !== 32'hFFFF_3CFF) begin failures++; $display("FAIL pw_readback got=%h exp=ffff3cff", ext_rdata); end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'hF000_0014, 32'h0);
        #1;
        checks += 1;
        if (ext_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt0 got=%b exp=1", ext_gnt); end
        @(negedge clk);
        checks += 1;
        if (ext_rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL b2b_rdata0 got=%h exp=a5a5a5a5", ext_rdata); end
        drive(1'b1, 1'b0, 4'hF, 32'hF000_0010, 32'h0);
        #1;
        checks += 1;
        if (ext_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt1 got=%b exp=1", ext_gnt); end
        @(negedge clk);
        checks += 2;
        if (ext_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_rvalid1 got=%b exp=1", ext_rvalid); end
        if (ext_rdata !== 32'hFFFF_3CFF) begin failures++; $display("FAIL b2b_rdata1 got=%h exp=ffff3cff", ext_rdata); end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'hF000_0014, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checks += 1;
        if (ext_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", ext_rvalid); end
        st = EXEC; mage_req = 8'h08; mage_addr[3] = 10'd7;
        drive(1'b1, 1'b0, 4'hF, 32'hF000_000C, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks += 1;
            if (ext_gnt !== (c == 5)) begin failures++; $display("FAIL rst_deny c=%0d got=%b exp=%b", c, ext_gnt, c == 5); end
            @(negedge clk);
        end
        st = IDLE; mage_req = '0;
        drive(1'b1, 1'b0, 4'hF, 32'hF000_0014, 32'h0);
        #1;
        checks += 1;
        if (ext_gnt !== 1'b1) begin failures++; $display("FAIL post_rst_gnt got=%b exp=1", ext_gnt); end
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checks += 1;
        if (ext_rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL post_rst_rdata got=%h exp=a5a5a5a5", ext_rdata); end
    endtask

    initial begin
        test_reset();
        test_write_k0();
        test_read_k10();
        test_conflict();
        test_oor();
        test_partial();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_bank_arbiter.md
Name: dmem_bank_arbiter

Overview:
- Parametrised successor to Mage's data-memory front end. It arbitrates per-bank access between the Mage PEA (one port per bank) and a single external bus port.
- Maps external byte addresses onto N_BANKS banks using a runtime-selectable power-of-two interleave granularity.
- Uses a req/gnt/rvalid handshake with conflict stalling, starvation protection, byte enables and an error response for out-of-range accesses.
- Sits between mage_top/external OBI-style bus and the banked data memory.

Parameters:
- N_BANKS, 8, number of banks; power of two, at least 2.
- BANK_ADDR_W, 10, word-address width of one bank.
- DATA_W, 32, bank and bus data width; multiple of 8.
- BASE_ADDR, 32'hF000_0000, external region base; aligned to 2^REGION_W.
- REGION_W, 20, log2 of region size in bytes.
- STALL_MAX, 4, consecutive denied external cycles before external wins priority; at least 1.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- state_i, in, state_t, Mage state; Mage ports are live only in EXEC.
- reg_block_size_i, in, 4, log2 of interleave granularity in words (k).
- mage_req_i, in, N_BANKS, per-bank request.
- mage_we_i, in, N_BANKS, per-bank write enable.
- mage_addr_i, in, N_BANKS x BANK_ADDR_W, per-bank word address.
- mage_wdata_i, in, N_BANKS x DATA_W, per-bank write data.
- mage_stall_o, out, N_BANKS, the bank's request was not serviced this cycle.
- mage_rvalid_o, out, N_BANKS, read data valid.
- mage_rdata_o, out, N_BANKS x DATA_W, read data; zero when rvalid is 0.
- ext_req_i, in, 1, external request.
- ext_we_i, in, 1, external write enable.
- ext_be_i, in, DATA_W/8, byte enables.
- ext_addr_i, in, 32, byte address.
- ext_wdata_i, in, DATA_W, write data.
- ext_gnt_o, out, 1, request accepted this cycle (combinational).
- ext_rvalid_o, out, 1, response valid.
- ext_rdata_o, out, DATA_W, read data; zero for writes and errors.
- ext_err_o, out, 1, out-of-range error; qualified by ext_rvalid_o.
- dmem_req_o, out, N_BANKS, bank request.
- dmem_we_o, out, N_BANKS, bank write enable.
- dmem_be_o, out, N_BANKS x DATA_W/8, bank byte enables; all-ones for Mage.
- dmem_addr_o, out, N_BANKS x BANK_ADDR_W, bank word address.
- dmem_wdata_o, out, N_BANKS x DATA_W, bank write data.
- dmem_rdata_i, in, N_BANKS x DATA_W, bank read data; one-cycle latency.

Behaviour:
- Address decode:
  - w = ext_addr_i >> log2(DATA_W/8); B = log2(N_BANKS); ke = min(reg_block_size_i, BANK_ADDR_W).
  - Bank index = w[ke +: B].
  - Bank address = {w[ke+B +: BANK_ADDR_W-ke], w[ke-1:0]}; when ke = 0 the low part is empty.
  - in_range = (ext_addr_i[31:REGION_W] == BASE_ADDR[31:REGION_W]) and (w >> (BANK_ADDR_W+B)) within the region is zero.
- Mage side:
  - Outside EXEC, mage_req_i is ignored and mage_stall_o = mage_req_i.
  - In EXEC, the Mage port drives its bank unless external holds priority on that bank this cycle.
- External arbitration, per cycle:
  - Out of range: ext_gnt_o = 1 with no bank access; next cycle ext_rvalid_o = 1, ext_err_o = 1, ext_rdata_o = 0.
  - In range, target bank free (no EXEC Mage request on it): grant.
  - In range, conflict with a Mage request: deny, deny_cnt++.
  - When deny_cnt == STALL_MAX: external is granted, the Mage request on that bank gets mage_stall_o = 1, and deny_cnt clears.
  - deny_cnt clears on any grant or when ext_req_i = 0. Width is $clog2(STALL_MAX+1).
- External requests are held by the master until granted; the block registers nothing before grant.
- Response pipeline:
  - One register stage holds: granted bank index, we, err, and a per-bank Mage read-accepted mask.
  - ext_rvalid_o is high exactly one cycle after every grant, for reads, writes and errors.
  - ext_rdata_o = dmem_rdata_i[reg_bank] for in-range reads, else 0.
  - mage_rvalid_o[i] is high one cycle after an unstalled Mage read on bank i.
- Back-to-back external grants every cycle are supported, giving a throughput of 1 per cycle.
- Simultaneous Mage reads on all banks plus an external access to a free bank cannot occur, since every bank is busy; the rule is simply "free bank means grant".
- Changing reg_block_size_i while a response is pending does not corrupt that response, because the bank index is registered.
- state_i leaving EXEC mid-transaction: responses already in the pipeline complete normally.
- Reset: deny_cnt = 0, response register cleared.
  - ext_rvalid_o, ext_err_o, mage_rvalid_o = 0; rdata outputs = 0.
  - Combinational outputs follow their inputs; dmem_req_o = 0 when there are no requests.

Decomposition:
- mage_pkg gains: DMEM_BASE_ADDR, DMEM_REGION_W, DMEM_STALL_MAX.
- mage_pkg gains the dmem_ext_rsp_t struct {bank, we, err}.
- state_t stays in mage_pkg.
- Sub-module dmem_addr_map (combinational: ext_addr_i, reg_block_size_i → bank index, bank address, in_range) is reused by the verification model.

Test Plan:
- k=0, external write 0xF000_0014, data 0xA5A5_A5A5, be=4'hF → bank 5, addr 0, gnt same cycle, rvalid next cycle with err=0; readback returns 0xA5A5_A5A5.
- k=10, external read 0xF000_1008 → bank 1, addr 2; rdata equals the bank-1 model word 2 one cycle after gnt.
- EXEC, Mage holds a bank-3 read every cycle, external to bank 3, STALL_MAX=4 → 4 denied cycles, grant on cycle 5 with mage_stall_o[3]=1 that cycle only.
- External read 0xE000_0000 → gnt, next cycle rvalid=1, err=1, rdata=0, dmem_req_o=0.
- Partial write be=4'b0010 over an existing 0xFFFF_FFFF → dmem_be_o matches 4'b0010 on the target bank; readback returns 0xFFFF_XXFF with only byte 1 changed.
- rst_i asserted the cycle after a grant → rvalid stays 0 and deny_cnt = 0; a new request afterwards is granted normally.
